ff_pin_driver: RTL and testbench
================================

// Module: ff_pin_driver
// PURPOSE
//  Multi-channel tester pin driver. Per channel, applies a programmable force-format to
//  pattern data inside a repeating tester cycle of CYCLE_LENGTH clocks, with per-channel
//  leading/trailing edge counts. Pattern vectors arrive through a one-deep shadow register
//  with a valid/ready handshake. Sits between the pattern sequencer and the DUT pin pads.
// PARAMETERS
//  NUM_CH  8  number of pin channels
//  CNT_W   8  width of cycle counter, CYCLE_LENGTH and each edge count
// PORTS
//  CLK            in   1           system clock; all logic on posedge
//  RST_N          in   1           asynchronous, active-low reset
//  EN             in   1           cycle counter advance enable
//  CYCLE_LENGTH   in   CNT_W       clocks per tester cycle
//  LEADING_EDGE   in   NUM_CH*CNT_W  per-channel leading-edge count, ch i at [i*CNT_W +: CNT_W]
//  TRAILING_EDGE  in   NUM_CH*CNT_W  per-channel trailing-edge count
//  FF             in   NUM_CH*3    per-channel format, ch i at [i*3 +: 3]
//  D              in   NUM_CH      pattern vector
//  D_VALID        in   1           D holds a new vector
//  D_READY        out  1           shadow register empty; vector accepted when D_VALID&&D_READY
//  Q              out  NUM_CH      driven pin values
//  OE             out  NUM_CH      per-channel drive enable (0 = high-Z at pad)
//  CYCLE_START    out  1           one-clock pulse on every cycle boundary
//  UNDERRUN       out  1           sticky: boundary occurred with shadow empty
// BEHAVIOUR
//  Reset: cnt=0, Q=0, OE=0, D_READY=1, CYCLE_START=0, UNDERRUN=0, shadow/active data=0,
//   active FF=101 (OFF), active config zeroed. Reset mid-cycle aborts the cycle immediately.
//  Counter: EN=0 freezes cnt, Q, OE. With EN=1: if cnt==0 or cnt==active CYCLE_LENGTH,
//   boundary edge: cnt<=1; else cnt<=cnt+1. CYCLE_LENGTH==0: cnt holds 0, no boundary, no edges.
//  Boundary edge: latch CYCLE_LENGTH, LEADING_EDGE, TRAILING_EDGE, FF into active copies; move
//   shadow into active data and set D_READY=1; CYCLE_START<=1 for that clock. Shadow empty at
//   boundary: active data unchanged, UNDERRUN<=1 (cleared only by reset). Inputs changed
//   mid-cycle take effect at next boundary only. OE<=1 unless new format is OFF/reserved.
//  Handshake: D_VALID&&D_READY loads shadow, D_READY<=0 next clock. Load on the boundary edge
//   itself: shadow-to-active moves old shadow, new vector fills shadow, D_READY stays 0.
//  Edge events (per channel, EN=1, compared against pre-increment cnt): leading when
//   cnt==LE, trailing when cnt==TE; Q updates on that same clock edge (1-clock latency from
//   cnt showing the value). LE or TE of 0 or > CYCLE_LENGTH never fires.
//  Formats (active FF): 000 R0: lead Q<=D, trail Q<=0. 001 R1: lead Q<=D, trail Q<=1.
//   010 DNRZ_L: lead Q<=D. 011 DNRZ_T: trail Q<=D. 100 SBC (see CONFIGURATION).
//   101 OFF, 110/111 reserved: OE=0, Q holds.
//  Priority on one clock edge: leading > trailing > boundary action. LE==TE: leading only.
//   Edge at cnt==CYCLE_LENGTH uses outgoing active data/config; edge at cnt==1 uses new.
//  TE<LE legal: trailing fires earlier in the cycle, values per format.
//  Widths: cnt is CNT_W bits, no overflow since cnt never exceeds CYCLE_LENGTH.
// CONFIGURATION
//  FF_SBC_EN defined: format 100 = surround-by-complement: boundary Q<=~D(new active),
//   lead Q<=D, trail Q<=~D; OE=1.
//  FF_SBC_EN undefined: format 100 behaves as OFF (OE=0, Q holds); no SBC logic built.
// TESTING
//  R0, CL=10, LE=3, TE=7, vectors 1,1,0: Q=1 clocks after cnt=3..7 each cycle, 0 elsewhere.
//  R1/DNRZ_L/DNRZ_T on ch0..2, CL=8, LE=2, TE=6, D alternating 1/0: R1 idles 1; DNRZ_L
//   changes after cnt=2; DNRZ_T after cnt=6; CYCLE_START every 8 clocks.
//  Hold D_VALID=0 across boundary -> UNDERRUN=1 and stays; Q repeats previous vector.
//  Change LE 3->5 at cnt=4 -> current cycle unaffected, next cycle leading at cnt=5.
//  LE=TE=4 R0 -> Q=D after cnt=4, no return; LE=12 with CL=10 -> no leading edge.
//  FF_SBC_EN, CL=10, LE=3, TE=7, D=1 -> Q=0 at cycle start, 1 after cnt=3, 0 after cnt=7;
//   assert RST_N low at cnt=5 -> Q=0, OE=0, D_READY=1 immediately.

Source files
------------

// File: rtl/ff_pin_driver.sv
// Multi-channel tester pin driver: per-channel force formats applied inside a repeating tester cycle.
// Define FF_SBC_EN to build the surround-by-complement format (100); otherwise 100 behaves as OFF.
module ff_pin_driver #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic [CNT_W-1:0]        CYCLE_LENGTH,
    input  logic [NUM_CH*CNT_W-1:0] LEADING_EDGE,
    input  logic [NUM_CH*CNT_W-1:0] TRAILING_EDGE,
    input  logic [NUM_CH*3-1:0]     FF,
    input  logic [NUM_CH-1:0]       D,
    input  logic                    D_VALID,
    output logic                    D_READY,
    output logic [NUM_CH-1:0]       Q,
    output logic [NUM_CH-1:0]       OE,
    output logic                    CYCLE_START,
    output logic                    UNDERRUN
);

    typedef enum logic [2:0] {
        FMT_R0     = 3'b000,
        FMT_R1     = 3'b001,
        FMT_DNRZ_L = 3'b010,
        FMT_DNRZ_T = 3'b011,
        FMT_SBC    = 3'b100,
        FMT_OFF    = 3'b101,
        FMT_RSV6   = 3'b110,
        FMT_RSV7   = 3'b111
    } fmt_e;

    function automatic logic fmt_drives(input logic [2:0] f);
`ifdef FF_SBC_EN
        return f <= FMT_SBC;
`else
        return f <= FMT_DNRZ_T;
`endif
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [NUM_CH*CNT_W-1:0] le_q, le_d;
    logic [NUM_CH*CNT_W-1:0] te_q, te_d;
    logic [NUM_CH*3-1:0]     ff_q, ff_d;
    logic [NUM_CH-1:0]       adat_q, adat_d;
    logic [NUM_CH-1:0]       sdat_q, sdat_d;
    logic [NUM_CH-1:0]       q_q, q_d;
    logic [NUM_CH-1:0]       oe_q, oe_d;
    logic                    ready_q, ready_d;
    logic                    cs_q, cs_d;
    logic                    ur_q, ur_d;
    logic                    boundary;
    logic                    load;
    logic [NUM_CH-1:0]       lead, trail;

    // A zero CYCLE_LENGTH parks the counter at 0 instead of starting a new cycle.
    always_comb begin
        boundary = 1'b0;
        cnt_d    = cnt_q;
        if (EN) begin
            if (cnt_q == '0 || cnt_q == len_q) begin
                boundary = (CYCLE_LENGTH != '0);
                cnt_d    = boundary ? CNT_W'(1) : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        load    = D_VALID && ready_q;
        len_d   = len_q;
        le_d    = le_q;
        te_d    = te_q;
        ff_d    = ff_q;
        adat_d  = adat_q;
        sdat_d  = sdat_q;
        ready_d = ready_q;
        ur_d    = ur_q;
        oe_d    = oe_q;
        cs_d    = boundary;
        if (boundary) begin
            len_d = CYCLE_LENGTH;
            le_d  = LEADING_EDGE;
            te_d  = TRAILING_EDGE;
            ff_d  = FF;
            if (!ready_q) begin
                adat_d  = sdat_q;
                ready_d = 1'b1;
            end else begin
                ur_d = 1'b1;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                oe_d[i] = fmt_drives(FF[i*3 +: 3]);
            end
        end
        // A load on the boundary edge refills the shadow just emptied above.
        if (load) begin
            sdat_d  = D;
            ready_d = 1'b0;
        end
    end

    // cnt never exceeds the active length, so LE/TE of 0 or beyond it can never match.
    always_comb begin
        lead  = '0;
        trail = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            lead[i]  = EN && (cnt_q != '0) && (cnt_q == le_q[i*CNT_W +: CNT_W]);
            trail[i] = EN && (cnt_q != '0) && (cnt_q == te_q[i*CNT_W +: CNT_W]);
        end
    end

    always_comb begin
        q_d = q_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (lead[i]) begin
                case (ff_q[i*3 +: 3])
                    FMT_R0, FMT_R1, FMT_DNRZ_L: q_d[i] = adat_q[i];
`ifdef FF_SBC_EN
                    FMT_SBC:                    q_d[i] = adat_q[i];
`endif
                    default: ;
                endcase
            end else if (trail[i]) begin
                case (ff_q[i*3 +: 3])
                    FMT_R0:     q_d[i] = 1'b0;
                    FMT_R1:     q_d[i] = 1'b1;
                    FMT_DNRZ_T: q_d[i] = adat_q[i];
`ifdef FF_SBC_EN
                    FMT_SBC:    q_d[i] = ~adat_q[i];
`endif
                    default: ;
                endcase
            end
`ifdef FF_SBC_EN
            else if (boundary && FF[i*3 +: 3] == FMT_SBC) begin
                q_d[i] = ~adat_d[i];
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q   <= '0;
            len_q   <= '0;
            le_q    <= '0;
            te_q    <= '0;
            ff_q    <= {NUM_CH{FMT_OFF}};
            adat_q  <= '0;
            sdat_q  <= '0;
            q_q     <= '0;
            oe_q    <= '0;
            ready_q <= 1'b1;
            cs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            le_q    <= le_d;
            te_q    <= te_d;
            ff_q    <= ff_d;
            adat_q  <= adat_d;
            sdat_q  <= sdat_d;
            q_q     <= q_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            cs_q    <= cs_d;
            ur_q    <= ur_d;
        end
    end

    assign D_READY     = ready_q;
    assign Q           = q_q;
    assign OE          = oe_q;
    assign CYCLE_START = cs_q;
    assign UNDERRUN    = ur_q;

endmodule

// File: tb/tb_ff_pin_driver.sv
// Testbench for ff_pin_driver: directed scenarios plus randomized traffic against a cycle-level model.
// Model honours FF_SBC_EN the same way the design build does.
module tb_ff_pin_driver;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;
`ifdef FF_SBC_EN
    localparam bit SBC = 1'b1;
`else
    localparam bit SBC = 1'b0;
`endif

    logic                    CLK = 1'b0;
    logic                    RST_N = 1'b0;
    logic                    EN = 1'b0;
    logic [CNT_W-1:0]        CYCLE_LENGTH = '0;
    logic [NUM_CH*CNT_W-1:0] LEADING_EDGE = '0;
    logic [NUM_CH*CNT_W-1:0] TRAILING_EDGE = '0;
    logic [NUM_CH*3-1:0]     FF = '0;
    logic [NUM_CH-1:0]       D = '0;
    logic                    D_VALID = 1'b0;
    logic                    D_READY;
    logic [NUM_CH-1:0]       Q;
    logic [NUM_CH-1:0]       OE;
    logic                    CYCLE_START;
    logic                    UNDERRUN;

    ff_pin_driver #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CYCLE_LENGTH(CYCLE_LENGTH),
        .LEADING_EDGE(LEADING_EDGE), .TRAILING_EDGE(TRAILING_EDGE), .FF(FF),
        .D(D), .D_VALID(D_VALID), .D_READY(D_READY), .Q(Q), .OE(OE),
        .CYCLE_START(CYCLE_START), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus configuration
    int cfg_cl;
    int cfg_le[NUM_CH];
    int cfg_te[NUM_CH];
    int cfg_ff[NUM_CH];
    int feed;
    logic [NUM_CH-1:0] vec_q[$];

    // reference model state
    int m_cnt, m_len;
    int m_le[NUM_CH];
    int m_te[NUM_CH];
    int m_ff[NUM_CH];
    bit [NUM_CH-1:0] m_act, m_q, m_oe;
    bit [NUM_CH-1:0] m_shadow[$];
    bit m_cs, m_ur;

    function automatic bit drives(input int f);
        return (f <= 3) || (SBC && f == 4);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_len = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_le[c] = 0;
            m_te[c] = 0;
            m_ff[c] = 5;
        end
        m_act = '0;
        m_q   = '0;
        m_oe  = '0;
        m_shadow.delete();
        m_cs = 1'b0;
        m_ur = 1'b0;
    endtask

    task automatic model_step();
        bit [NUM_CH-1:0] nq, newd;
        bit empty, bnd, lead, trail;
        int f, nf;
        nq    = m_q;
        newd  = m_act;
        empty = (m_shadow.size() == 0);
        bnd   = 1'b0;
        if (EN) begin
            bnd = (m_cnt == 0 || m_cnt == m_len) && (CYCLE_LENGTH != 0);
            if (bnd) begin
                if (!empty) newd = m_shadow.pop_front();
                else m_ur = 1'b1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                f     = m_ff[c];
                nf    = int'(FF[c*3 +: 3]);
                lead  = (m_cnt != 0) && (m_cnt == m_le[c]);
                trail = (m_cnt != 0) && (m_cnt == m_te[c]);
                if (lead) begin
                    if (f <= 2 || (SBC && f == 4)) nq[c] = m_act[c];
                end else if (trail) begin
                    if (f == 0) nq[c] = 1'b0;
                    else if (f == 1) nq[c] = 1'b1;
                    else if (f == 3) nq[c] = m_act[c];
                    else if (SBC && f == 4) nq[c] = ~m_act[c];
                end else if (bnd && SBC && nf == 4) begin
                    nq[c] = ~newd[c];
                end
            end
            if (bnd) m_cnt = 1;
            else if (m_cnt == 0 || m_cnt == m_len) m_cnt = 0;
            else m_cnt++;
        end
        if (D_VALID && empty) begin
            m_shadow.push_back(D);
            if (vec_q.size() != 0) void'(vec_q.pop_front());
        end
        m_cs = bnd;
        m_q  = nq;
        if (bnd) begin
            m_len = int'(CYCLE_LENGTH);
            for (int c = 0; c < NUM_CH; c++) begin
                m_le[c] = int'(LEADING_EDGE[c*CNT_W +: CNT_W]);
                m_te[c] = int'(TRAILING_EDGE[c*CNT_W +: CNT_W]);
                m_ff[c] = int'(FF[c*3 +: 3]);
                m_oe[c] = drives(m_ff[c]);
            end
            m_act = newd;
        end
    endtask

    task automatic compare_all();
        check_eq("Q", Q, m_q);
        check_eq("OE", OE, m_oe);
        check_eq("D_READY", D_READY, m_shadow.size() == 0);
        check_eq("CYCLE_START", CYCLE_START, m_cs);
        check_eq("UNDERRUN", UNDERRUN, m_ur);
    endtask

    task automatic apply_cfg();
        for (int c = 0; c < NUM_CH; c++) begin
            LEADING_EDGE[c*CNT_W +: CNT_W]  = CNT_W'(cfg_le[c]);
            TRAILING_EDGE[c*CNT_W +: CNT_W] = CNT_W'(cfg_te[c]);
            FF[c*3 +: 3] = 3'(cfg_ff[c]);
        end
        CYCLE_LENGTH = CNT_W'(cfg_cl);
    endtask

    task automatic set_all(input int fmt, input int cl, input int le, input int te);
        cfg_cl = cl;
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_ff[c] = fmt;
            cfg_le[c] = le;
            cfg_te[c] = te;
        end
        apply_cfg();
    endtask

    task automatic drive_feed();
        if (vec_q.size() != 0) begin
            D_VALID = 1'b1;
            D = vec_q[0];
        end else if (feed == 1) begin
            D_VALID = 1'b1;
            D = NUM_CH'($urandom);
        end else if (feed == 2) begin
            D_VALID = ($urandom_range(0, 9) < 7);
            D = NUM_CH'($urandom);
        end else begin
            D_VALID = 1'b0;
        end
    endtask

    task automatic tick();
        drive_feed();
        @(posedge CLK);
        if (RST_N) model_step();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at a negedge: asserts reset mid-cycle and checks the immediate effect.
    task automatic do_reset();
        D_VALID = 1'b0;
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all();
        check_eq("rst_Q", Q, 0);
        check_eq("rst_OE", OE, 0);
        check_eq("rst_D_READY", D_READY, 1);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic wait_model_cnt(input string tag, input int target);
        for (int i = 0; i < 40 && m_cnt != target; i++) tick();
        check_eq(tag, m_cnt, target);
    endtask

    initial begin
        model_reset();
        feed = 0;
        repeat (2) @(negedge CLK);
        compare_all();
        check_eq("reset_UNDERRUN", UNDERRUN, 0);
        check_eq("reset_CYCLE_START", CYCLE_START, 0);
        RST_N = 1'b1;

        // R0, CL=10 LE=3 TE=7, vectors 1,1,0; then starve the shadow
        set_all(0, 10, 3, 7);
        vec_q.push_back('1);
        vec_q.push_back('1);
        vec_q.push_back('0);
        run(2);
        EN = 1'b1;
        run(45);
        check_eq("underrun_sticky", UNDERRUN, 1);
        do_reset();

        // R1 / DNRZ_L / DNRZ_T, CL=8 LE=2 TE=6, alternating vectors
        set_all(0, 8, 2, 6);
        cfg_ff[0] = 1;
        cfg_ff[1] = 2;
        cfg_ff[2] = 3;
        apply_cfg();
        for (int i = 0; i < 6; i++) begin
            vec_q.push_back('1);
            vec_q.push_back('0);
        end
        feed = 1;
        run(70);

        // LE 3->5 changed mid-cycle at cnt=4
        set_all(0, 10, 3, 7);
        wait_model_cnt("wait_cnt4", 4);
        set_all(0, 10, 5, 7);
        run(25);

        // LE=TE=4, then LE beyond the cycle length
        set_all(0, 10, 4, 4);
        run(25);
        set_all(0, 10, 12, 7);
        run(25);

        // format 100 with D=1, reset asserted mid-cycle at cnt=5
        set_all(4, 10, 3, 7);
        feed = 0;
        for (int i = 0; i < 4; i++) vec_q.push_back('1);
        run(22);
        wait_model_cnt("wait_cnt5", 5);
        do_reset();
        vec_q.delete();

        // randomized traffic
        feed = 2;
        for (int i = 0; i < 3000; i++) begin
            EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) begin
                cfg_cl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
                for (int c = 0; c < NUM_CH; c++) begin
                    cfg_le[c] = int'($urandom_range(0, 17));
                    cfg_te[c] = int'($urandom_range(0, 17));
                    cfg_ff[c] = int'($urandom_range(0, 7));
                end
                apply_cfg();
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
